// File: rtl/keccak_out_writer.sv
// keccak_out_writer: result-side packer for the Keccak test harness.
// Captures digest/XOF lanes streamed out of the core and stores one record per
// test in an on-chip result buffer: a header word followed by the digest words,
// with the final word masked to the output length. A registered read port lets
// the bench dump the buffer afterwards.
//
// Optional feature macro: KECCAK_WR_CHECKSUM_EN
//   defined   : each record also ends with an XOR checksum trailer word
//               (record length nwords+2, finish_hash one cycle later).
//   undefined : record length nwords+1, no checksum logic.

module keccak_out_writer #(
  parameter int DATA_LENGTH = 64,
  parameter int MEM_SIZE    = 4096,
  parameter int PTR_LENGTH  = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [2:0]             cmode,
  input  logic [10:0]            d,
  input  logic                   out_valid,
  input  logic [DATA_LENGTH-1:0] out_data,
  output logic                   out_ready,
  output logic                   finish_hash,
  output logic [15:0]            test_count,
  output logic [PTR_LENGTH-1:0]  wr_ptr,
  output logic                   overflow,
  output logic                   mode_err,
  input  logic [PTR_LENGTH-1:0]  rd_addr,
  output logic [DATA_LENGTH-1:0] rd_data
);

  // Index width of the buffer itself; pointers are one bit wider so that the
  // "full" value MEM_SIZE is representable.
  localparam int ADDR_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [PTR_LENGTH-1:0] FULL_PTR = PTR_LENGTH'(MEM_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_CAPT  = 3'd2,
    ST_DONE  = 3'd4
`ifdef KECCAK_WR_CHECKSUM_EN
    ,
    ST_TRAIL = 3'd3
`endif
  } state_t;

  state_t state;

  // Per-test configuration latched in IDLE.
  logic [2:0]  cur_cmode;
  logic [10:0] cur_len;
  logic [5:0]  cur_nwords;   // 0..32
  logic [5:0]  word_idx;     // index of the next digest word

`ifdef KECCAK_WR_CHECKSUM_EN
  logic [DATA_LENGTH-1:0] csum;
`endif

  // Result buffer. Contents survive reset by design.
  logic [DATA_LENGTH-1:0] mem [MEM_SIZE];

  // ---------------------------------------------------------------------------
  // Configuration decode: output length in bits and word count for the
  // incoming cmode/d. Invalid modes (6/7) yield a zero-length record.
  // ---------------------------------------------------------------------------
  logic [10:0] len_sel;
  logic [5:0]  nwords_sel;
  logic        mode_bad;

  // Decode requested length, word count and mode validity.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    len_sel  = 11'd0;
    mode_bad = 1'b0;
    case (cmode)
      3'd0:    len_sel = 11'd224;
      3'd1:    len_sel = 11'd256;
      3'd2:    len_sel = 11'd384;
      3'd3:    len_sel = 11'd512;
      3'd4,
      3'd5:    len_sel = d;
      default: mode_bad = 1'b1;
    endcase
    // 12-bit sum: d=2047 gives 2110, still in range, so 32 words.
    nwords_sel = 6'((12'({1'b0, len_sel}) + 12'd63) >> 6);
  end

  // ---------------------------------------------------------------------------
  // Write datapath: header, masked digest word or checksum trailer.
  // ---------------------------------------------------------------------------
  logic                   last_word;
  logic [5:0]             rem_bits;
  logic [DATA_LENGTH-1:0] lane_mask;
  logic [DATA_LENGTH-1:0] masked_lane;
  logic [DATA_LENGTH-1:0] header_word;
  logic                   accept;
  logic                   wr_en;
  logic [DATA_LENGTH-1:0] wr_data;
  logic                   mem_we;

  // Mask the final digest word down to len mod 64 bits (0 keeps all bits).
  always_comb begin
    rem_bits    = cur_len[5:0];
    last_word   = (word_idx == (cur_nwords - 6'd1));
    lane_mask   = '1;
    if (last_word && (rem_bits != 6'd0)) begin
      lane_mask = (DATA_LENGTH'(1) << rem_bits) - DATA_LENGTH'(1);
    end
    masked_lane = out_data & lane_mask;
    header_word = DATA_LENGTH'({test_count, 13'b0, cur_cmode, 5'b0, cur_len,
                                10'b0, cur_nwords});
  end

  // Select what, if anything, is written to the buffer this cycle.
  always_comb begin
    accept  = (state == ST_CAPT) && out_valid && out_ready;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state)
      ST_HDR: begin
        wr_en   = 1'b1;
        wr_data = header_word;
      end
      ST_CAPT: begin
        wr_en   = accept;
        wr_data = masked_lane;
      end
`ifdef KECCAK_WR_CHECKSUM_EN
      ST_TRAIL: begin
        wr_en   = 1'b1;
        wr_data = csum;
      end
`endif
      default: begin
        wr_en   = 1'b0;
        wr_data = '0;
      end
    endcase
    // A full buffer drops the word; the handshake still completes.
    mem_we = wr_en && (wr_ptr != FULL_PTR) && !rst;
  end

  // ---------------------------------------------------------------------------
  // Record state machine with registered handshake and status outputs.
  // ---------------------------------------------------------------------------

  // Sequence IDLE -> HDR -> CAPT -> (TRAIL) -> DONE and keep status counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state       <= ST_IDLE;
      out_ready   <= 1'b0;
      finish_hash <= 1'b0;
      test_count  <= 16'd0;
      wr_ptr      <= '0;
      overflow    <= 1'b0;
      mode_err    <= 1'b0;
      cur_cmode   <= 3'd0;
      cur_len     <= 11'd0;
      cur_nwords  <= 6'd0;
      word_idx    <= 6'd0;
`ifdef KECCAK_WR_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      finish_hash <= 1'b0;

      // Pointer saturates at MEM_SIZE; a dropped write marks overflow.
      if (wr_en) begin
        if (wr_ptr == FULL_PTR) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (cfg_load) begin
            cur_cmode  <= cmode;
            cur_len    <= len_sel;
            cur_nwords <= nwords_sel;
            if (mode_bad) begin
              mode_err <= 1'b1;
            end
            state <= ST_HDR;
          end
        end

        ST_HDR: begin
          word_idx <= 6'd0;
`ifdef KECCAK_WR_CHECKSUM_EN
          csum     <= '0;
`endif
          if (cur_nwords != 6'd0) begin
            out_ready <= 1'b1;
            state     <= ST_CAPT;
          end else begin
`ifdef KECCAK_WR_CHECKSUM_EN
            state       <= ST_TRAIL;
`else
            finish_hash <= 1'b1;
            test_count  <= test_count + 16'd1;
            state       <= ST_DONE;
`endif
          end
        end

        ST_CAPT: begin
          if (accept) begin
            word_idx <= word_idx + 6'd1;
`ifdef KECCAK_WR_CHECKSUM_EN
            csum     <= csum ^ masked_lane;
`endif
            if (last_word) begin
              out_ready <= 1'b0;
`ifdef KECCAK_WR_CHECKSUM_EN
              state       <= ST_TRAIL;
`else
              finish_hash <= 1'b1;
              test_count  <= test_count + 16'd1;
              state       <= ST_DONE;
`endif
            end
          end
        end

`ifdef KECCAK_WR_CHECKSUM_EN
        ST_TRAIL: begin
          finish_hash <= 1'b1;
          test_count  <= test_count + 16'd1;
          state       <= ST_DONE;
        end
`endif

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state     <= ST_IDLE;
          out_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer write and registered read port.
  // ---------------------------------------------------------------------------

  // Store the selected word at the write pointer.
  always_ff @(posedge clk) begin
    // NOTE: the buffer array has no reset; clearing it would prevent RAM
    // inference, and stale contents are never read as part of a new record.
    if (mem_we) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Registered read: old data on a same-cycle write, zero beyond the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr < FULL_PTR) begin
      rd_data <= mem[rd_addr[ADDR_W-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_keccak_out_writer.sv
// Self-checking bench for keccak_out_writer.
// A transaction-level model (expected record words, pointer, flags and the
// cycle at which each visible output changes) is advanced by the stimulus
// driver; one compare process checks the DUT status outputs every cycle, and
// directed literal checks pin the model for the reference scenarios.
// Honours KECCAK_WR_CHECKSUM_EN the same way as the design.

module tb_keccak_out_writer;

  localparam int DW  = 64;
  localparam int MEM = 64;
  localparam int PW  = 7;
`ifdef KECCAK_WR_CHECKSUM_EN
  localparam int REC_X = 2;
`else
  localparam int REC_X = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [2:0]    cmode;
  logic [10:0]   d;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          finish_hash;
  logic [15:0]   test_count;
  logic [PW-1:0] wr_ptr;
  logic          overflow;
  logic          mode_err;
  logic [PW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  keccak_out_writer #(
    .DATA_LENGTH (DW),
    .MEM_SIZE    (MEM),
    .PTR_LENGTH  (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cmode       (cmode),
    .d           (d),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .finish_hash (finish_hash),
    .test_count  (test_count),
    .wr_ptr      (wr_ptr),
    .overflow    (overflow),
    .mode_err    (mode_err),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] mmem [MEM];
  bit            mvalid [MEM];
  int            exp_wp;
  bit            exp_ready, exp_finish, exp_ovf, exp_merr;
  logic [15:0]   exp_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int len_of(input logic [2:0] m, input logic [10:0] dd);
    case (m)
      3'd0: return 224;
      3'd1: return 256;
      3'd2: return 384;
      3'd3: return 512;
      3'd4, 3'd5: return int'(dd);
      default: return 0;
    endcase
  endfunction

  // Keep only the low (len mod 64) bits of the final word.
  function automatic logic [63:0] trunc(input logic [63:0] w, input int len);
    int r;
    r = len % 64;
    if (r == 0) return w;
    return w & ~(64'hFFFF_FFFF_FFFF_FFFF << r);
  endfunction

  function automatic logic [63:0] lane_for(input int kind, input int idx);
    logic [3:0] nib;
    nib = 4'(idx + 1);
    case (kind)
      1: return {16{nib}};
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic model_write(input logic [63:0] w);
    if (exp_wp == MEM) begin
      exp_ovf = 1'b1;
    end else begin
      mmem[exp_wp]   = w;
      mvalid[exp_wp] = 1'b1;
      exp_wp++;
    end
  endtask

  task automatic model_reset();
    exp_wp     = 0;
    exp_ready  = 1'b0;
    exp_finish = 1'b0;
    exp_ovf    = 1'b0;
    exp_merr   = 1'b0;
    exp_count  = 16'd0;
  endtask

  task automatic record_done();
    exp_finish = 1'b1;
    exp_count  = exp_count + 16'd1;
  endtask

  // Status outputs compared against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_ready",   64'(out_ready),   64'(exp_ready));
      check("finish_hash", 64'(finish_hash), 64'(exp_finish));
      check("test_count",  64'(test_count),  64'(exp_count));
      check("wr_ptr",      64'(wr_ptr),      64'(exp_wp));
      check("overflow",    64'(overflow),    64'(exp_ovf));
      check("mode_err",    64'(mode_err),    64'(exp_merr));
    end
  end

  task automatic read_word(input int a, output logic [63:0] v);
    rd_addr = PW'(a);
    tick();
    v = rd_data;
  endtask

  // One test: cfg_load, then lanes with random valid gaps. abort_at >= 0
  // asserts reset just before that word index.
  task automatic run_test(input logic [2:0] m, input logic [10:0] dd,
                          input int kind, input int abort_at);
    int len, nw, idx;
    logic [63:0] lane, w, prev;
    bit prev_known;
`ifdef KECCAK_WR_CHECKSUM_EN
    logic [63:0] csum;
    csum = 64'd0;
`endif
    len = len_of(m, dd);
    nw  = (len + 63) / 64;

    cfg_load  = 1'b1;
    cmode     = m;
    d         = dd;
    out_valid = 1'($urandom_range(0, 1));
    out_data  = {$urandom, $urandom};
    tick();                                   // cfg_load accepted
    if (m >= 3'd6) exp_merr = 1'b1;
    cfg_load = 1'b0;
    cmode    = 3'($urandom);
    d        = 11'($urandom);
    tick();                                   // header written
    model_write(64'(exp_count) << 48 | 64'(m) << 32 | 64'(len) << 16 | 64'(nw));
    exp_ready = (nw > 0);
`ifndef KECCAK_WR_CHECKSUM_EN
    if (nw == 0) record_done();
`endif

    idx = 0;
    while (idx < nw) begin
      if (idx == abort_at) begin
        rst       = 1'b1;
        out_valid = 1'b0;
        cfg_load  = 1'b0;
        tick();
        model_reset();
        rst = 1'b0;
        check("rst_out_ready", 64'(out_ready), 64'd0);
        check("rst_wr_ptr",    64'(wr_ptr),    64'd0);
        check("rst_count",     64'(test_count), 64'd0);
        return;
      end
      lane      = lane_for(kind, idx);
      out_valid = ($urandom_range(0, 3) != 0);
      out_data  = lane;
      // Stray configuration pulses while capturing must be ignored.
      cfg_load  = ($urandom_range(0, 7) == 0);
      cmode     = 3'($urandom);
      d         = 11'($urandom);
      rd_addr   = PW'(exp_wp);
      prev_known = (exp_wp < MEM) && mvalid[exp_wp];
      prev       = prev_known ? mmem[exp_wp] : 64'd0;
      tick();
      if (prev_known) check("rd_old_data", rd_data, prev);
      if (out_valid) begin
        w = (idx == nw - 1) ? trunc(lane, len) : lane;
`ifdef KECCAK_WR_CHECKSUM_EN
        csum = csum ^ w;
`endif
        model_write(w);
        idx++;
        if (idx == nw) begin
          exp_ready = 1'b0;
`ifndef KECCAK_WR_CHECKSUM_EN
          record_done();
`endif
        end
      end
    end
    cfg_load  = 1'b0;
    out_valid = 1'($urandom_range(0, 1));
`ifdef KECCAK_WR_CHECKSUM_EN
    tick();                                   // trailer written
    model_write(csum);
    record_done();
`endif
    tick();                                   // pulse ends
    exp_finish = 1'b0;
    out_valid  = 1'b0;
  endtask

  task automatic sweep();
    logic [63:0] v;
    for (int a = 0; a < 2 * MEM; a++) begin
      read_word(a, v);
      if (a >= MEM) check("rd_beyond", v, 64'd0);
      else if (mvalid[a]) check("rd_sweep", v, mmem[a]);
    end
  endtask

  function automatic logic [10:0] pick_d();
    case ($urandom_range(0, 7))
      0: return 11'd0;
      1: return 11'd1;
      2: return 11'd63;
      3: return 11'd64;
      4: return 11'd65;
      5: return 11'd2047;
      default: return 11'($urandom_range(0, 2047));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int base;
    logic [2:0] m;
    int ab, len;

    for (int i = 0; i < MEM; i++) mvalid[i] = 1'b0;
    rst = 1'b1; cfg_load = 1'b0; cmode = 3'd0; d = 11'd0;
    out_valid = 1'b0; out_data = 64'd0; rd_addr = '0;
    model_reset();
    tick();
    tick();
    check("rst_rd_data", rd_data, 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    tick();

    // SHA3-256 reference record.
    run_test(3'd1, 11'd0, 1, -1);
    check("t1_wr_ptr", 64'(wr_ptr), 64'(4 + REC_X));
    check("t1_count",  64'(test_count), 64'd1);
    read_word(0, v); check("t1_header", v, 64'h0000_0001_0100_0004);
    read_word(1, v); check("t1_lane0",  v, 64'h1111_1111_1111_1111);
    read_word(4, v); check("t1_lane3",  v, 64'h4444_4444_4444_4444);
`ifdef KECCAK_WR_CHECKSUM_EN
    read_word(5, v); check("t1_trailer", v, 64'h4444_4444_4444_4444);
`endif

    // SHA3-224: final word keeps 32 bits.
    base = 4 + REC_X;
    run_test(3'd0, 11'd0, 2, -1);
    read_word(base,     v); check("t2_header", v, 64'h0001_0000_00E0_0004);
    read_word(base + 4, v); check("t2_last",   v, 64'h0000_0000_FFFF_FFFF);

    // SHAKE128 d=0: header only.
    base = 2 * (4 + REC_X);
    run_test(3'd4, 11'd0, 0, -1);
    read_word(base, v); check("t3_header", v, 64'h0002_0004_0000_0000);

    // SHAKE256 d=2047: 32 words, last masked to 63 bits.
    base = base + REC_X;
    run_test(3'd5, 11'd2047, 2, -1);
    read_word(base,      v); check("t4_header", v, 64'h0003_0005_07FF_0020);
    read_word(base + 32, v); check("t4_last",   v, 64'h7FFF_FFFF_FFFF_FFFF);

    // Invalid mode.
    base = base + 32 + REC_X;
    run_test(3'd7, 11'd100, 0, -1);
    check("t5_mode_err", 64'(mode_err), 64'd1);
    read_word(base, v); check("t5_header", v, 64'h0004_0007_0000_0000);

    // Fill the buffer and run past it.
    while (exp_wp < MEM) run_test(3'($urandom_range(0, 5)), pick_d(), 0, -1);
    run_test(3'd3, 11'd0, 0, -1);
    run_test(3'd3, 11'd0, 0, -1);
    check("full_overflow", 64'(overflow), 64'd1);
    check("full_wr_ptr",   64'(wr_ptr),   64'(MEM));
    sweep();

    // Reset in the middle of a capture.
    run_test(3'd5, 11'd700, 0, 3);
    tick();

    // Randomised records, occasionally abandoned by reset.
    for (int t = 0; t < 40; t++) begin
      m   = 3'($urandom_range(0, 7));
      d   = pick_d();
      len = len_of(m, d);
      ab  = -1;
      if (len > 0 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, (len + 63) / 64 - 1);
      run_test(m, d, 0, ab);
      repeat ($urandom_range(0, 2)) tick();
    end
    sweep();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
